wb_commit: RTL and testbench

WB_COMMIT -- requirements
Module: wb_commit

---
 rtl/wb_commit.sv | 143 ++++++++++++++
 tb/tb_wb_commit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback/commit stage: buffers exec results in a small FIFO, retires them in order,
// and turns taken branches and exceptions into a single redirect pulse plus a wrong-path drain.
module wb_commit #(
  parameter int XLEN      = 64,
  parameter int DEPTH     = 2,   // power of two, >= 2
  parameter int FLUSH_CYC = 2    // >= 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_rd_we,
  input  logic [4:0]      in_rd_idx,
  input  logic [XLEN-1:0] in_rd_val,
  input  logic            in_br_valid,
  input  logic [XLEN-1:0] in_br_target,
  input  logic            in_ex_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] epc,
  output logic [63:0]     retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rd_we;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_val;
    logic            br_valid;
    logic [XLEN-1:0] br_target;
    logic            ex_valid;
  } entry_t;

  typedef enum logic [1:0] {RUN, REDIR, DRAIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  entry_t          r_mem [DEPTH];
  logic [1:0]      r_rst_sync;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] r_epc;
  logic [63:0]     r_retire_cnt;

  logic            w_rst_n;
  logic            w_empty, w_full;
  logic            w_commit, w_redir, w_push;
  entry_t          w_head, w_in;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign in_ready = (r_state != REDIR) && !w_full;

  assign w_commit = (r_state == RUN) && !w_empty;
  assign w_redir  = w_commit && (w_head.ex_valid || w_head.br_valid);
  // Pushes outside RUN are wrong-path; a push alongside a redirect is dropped too.
  assign w_push   = in_valid && in_ready && (r_state == RUN) && !w_redir;

  always_comb begin
    w_in           = '0;
    w_in.pc        = in_pc;
    w_in.rd_we     = in_rd_we;
    w_in.rd_idx    = in_rd_idx;
    w_in.rd_val    = in_rd_val;
    w_in.br_valid  = in_br_valid;
    w_in.br_target = in_br_target;
    w_in.ex_valid  = in_ex_valid;
  end

  always_comb begin
    rf_we    = w_commit && w_head.rd_we && (w_head.rd_idx != 5'd0) && !w_head.ex_valid;
    rf_waddr = rf_we ? w_head.rd_idx : 5'd0;
    rf_wdata = rf_we ? w_head.rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_in;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state          <= RUN;
      r_drain_cnt      <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_epc            <= '0;
      r_retire_cnt     <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_redir) begin
            r_state          <= REDIR;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_head.ex_valid ? trap_vec : w_head.br_target;
            if (w_head.ex_valid) r_epc <= w_head.pc;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
          end else begin
            if (w_commit) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
        REDIR: begin
          r_state     <= DRAIN;
          r_drain_cnt <= CW'(FLUSH_CYC - 1);
        end
        DRAIN: begin
          if (r_drain_cnt == '0) r_state <= RUN;
          else                   r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: r_state <= RUN;
      endcase
      if (w_commit && !w_head.ex_valid) r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign epc            = r_epc;
  assign retire_cnt     = r_retire_cnt;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: single-entry vector table, then redirect, exception,
// streaming and reset-during-drain sequences checked against hand-computed values.
module tb_wb_commit;
  localparam int XLEN = 64;
  localparam int DEPTH = 2;
  localparam int FLUSH_CYC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_rd_val, in_br_target, trap_vec;
  logic            in_rd_we, in_br_valid, in_ex_valid;
  logic [4:0]      in_rd_idx;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata, redirect_pc, epc;
  logic            redirect_valid;
  logic [63:0]     retire_cnt;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_retire = 0;

  always #5 clk = ~clk;

  wb_commit #(.XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd_we(in_rd_we), .in_rd_idx(in_rd_idx), .in_rd_val(in_rd_val),
    .in_br_valid(in_br_valid), .in_br_target(in_br_target), .in_ex_valid(in_ex_valid),
    .trap_vec(trap_vec),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc(epc), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic        we;
    logic [4:0]  idx;
    logic [63:0] val;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] val;
  } sb_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic to_pos;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    in_valid = 0; in_pc = '0; in_rd_we = 0; in_rd_idx = '0; in_rd_val = '0;
    in_br_valid = 0; in_br_target = '0; in_ex_valid = 0;
  endtask

  task automatic drive(input logic [63:0] pc, input logic we, input logic [4:0] idx,
                       input logic [63:0] val, input logic br, input logic [63:0] tgt,
                       input logic ex);
    in_valid = 1; in_pc = pc; in_rd_we = we; in_rd_idx = idx; in_rd_val = val;
    in_br_valid = br; in_br_target = tgt; in_ex_valid = ex;
  endtask

  // Push one plain entry, then check its commit and the count afterwards.
  task automatic push_commit(input string name, input logic [63:0] pc, input logic we,
                             input logic [4:0] idx, input logic [63:0] val,
                             input logic exp_we, input logic [4:0] exp_addr,
                             input logic [63:0] exp_data);
    drive(pc, we, idx, val, 0, '0, 0);
    @(negedge clk); chk({name, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    to_pos;
    idle;
    @(negedge clk);
    chk({name, ".rf_we"}, {63'd0, rf_we}, {63'd0, exp_we});
    chk({name, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, exp_addr});
    chk({name, ".rf_wdata"}, rf_wdata, exp_data);
    exp_retire++;
    to_pos;
    chk({name, ".retire_cnt"}, retire_cnt, exp_retire);
  endtask

  vec_t vecs[5];
  sb_t  q[$];

  initial begin
    vecs[0] = '{64'h100, 1, 5'd5,  64'hAB,                  1, 5'd5,  64'hAB};
    vecs[1] = '{64'h104, 1, 5'd0,  64'h55,                  0, 5'd0,  64'h0};
    vecs[2] = '{64'h108, 0, 5'd7,  64'h77,                  0, 5'd0,  64'h0};
    vecs[3] = '{64'h10C, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{64'h110, 1, 5'd1,  64'h8000_0000_0000_0000, 1, 5'd1,  64'h8000_0000_0000_0000};

    trap_vec = 64'h80;
    idle;
    rst = 0;
    repeat (2) to_pos;
    @(negedge clk);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst.rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst.redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst.redirect_pc", redirect_pc, 64'd0);
    chk("rst.epc", epc, 64'd0);
    chk("rst.retire_cnt", retire_cnt, 64'd0);
    rst = 1;
    repeat (3) to_pos;

    for (int i = 0; i < 5; i++)
      push_commit($sformatf("vec%0d", i), vecs[i].pc, vecs[i].we, vecs[i].idx, vecs[i].val,
                  vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data);

    // JAL followed by wrong-path entries.
    drive(64'h200, 1, 5'd1, 64'h204, 1, 64'h300, 0);
    @(negedge clk); chk("jal.in_ready", {63'd0, in_ready}, 64'd1);
    to_pos;
    drive(64'h204, 1, 5'd2, 64'h11, 0, '0, 0);
    @(negedge clk);
    chk("jal.rf_we", {63'd0, rf_we}, 64'd1);
    chk("jal.rf_waddr", {59'd0, rf_waddr}, 64'd1);
    chk("jal.rf_wdata", rf_wdata, 64'h204);
    chk("jal.redir_early", {63'd0, redirect_valid}, 64'd0);
    exp_retire++;
    to_pos;
    drive(64'h208, 1, 5'd3, 64'h22, 0, '0, 0);
    @(negedge clk);
    chk("jal.redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("jal.redirect_pc", redirect_pc, 64'h300);
    chk("jal.redir_in_ready", {63'd0, in_ready}, 64'd0);
    chk("jal.redir_rf_we", {63'd0, rf_we}, 64'd0);
    chk("jal.retire_cnt", retire_cnt, exp_retire);
    for (int d = 0; d < FLUSH_CYC; d++) begin
      to_pos;
      drive(64'h300 + 64'(d * 4), 1, 5'd4, 64'h33, 0, '0, 0);
      @(negedge clk);
      chk($sformatf("jal.drain%0d.in_ready", d), {63'd0, in_ready}, 64'd1);
      chk($sformatf("jal.drain%0d.rf_we", d), {63'd0, rf_we}, 64'd0);
      chk($sformatf("jal.drain%0d.redirect_valid", d), {63'd0, redirect_valid}, 64'd0);
    end
    to_pos;
    idle;
    @(negedge clk);
    chk("jal.post.rf_we", {63'd0, rf_we}, 64'd0);
    chk("jal.post.in_ready", {63'd0, in_ready}, 64'd1);
    to_pos;
    @(negedge clk);
    chk("jal.post2.rf_we", {63'd0, rf_we}, 64'd0);
    chk("jal.post.retire_cnt", retire_cnt, exp_retire);
    to_pos;
    push_commit("after_jal", 64'h300, 1, 5'd4, 64'h44, 1, 5'd4, 64'h44);

    // Exception with br_valid also set: exception wins.
    drive(64'h400, 1, 5'd3, 64'h99, 1, 64'h500, 1);
    @(negedge clk);
    to_pos;
    idle;
    @(negedge clk);
    chk("exc.rf_we", {63'd0, rf_we}, 64'd0);
    chk("exc.rf_waddr", {59'd0, rf_waddr}, 64'd0);
    to_pos;
    @(negedge clk);
    chk("exc.redirect_valid", {63'd0, redirect_valid}, 64'd1);
    chk("exc.redirect_pc", redirect_pc, 64'h80);
    chk("exc.epc", epc, 64'h400);
    chk("exc.retire_cnt", retire_cnt, exp_retire);
    to_pos;
    @(negedge clk);
    chk("exc.pulse_len", {63'd0, redirect_valid}, 64'd0);
    repeat (FLUSH_CYC) to_pos;

    // Continuous stream with a scoreboard; FIFO occupancy is modelled by the queue.
    begin
      int accepted = 0;
      int cyc = 0;
      logic pop, acc;
      sb_t e;
      while (accepted < 100 && cyc < 1000) begin
        drive(64'h1000 + 64'(cyc * 4), 1, 5'($urandom_range(1, 31)),
              {32'($urandom), 32'($urandom)}, 0, '0, 0);
        @(negedge clk);
        chk("stream.in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
        pop = 0;
        if (q.size() > 0) begin
          chk("stream.rf_we", {63'd0, rf_we}, 64'd1);
          chk("stream.rf_waddr", {59'd0, rf_waddr}, {59'd0, q[0].idx});
          chk("stream.rf_wdata", rf_wdata, q[0].val);
          pop = 1;
        end else chk("stream.idle_rf_we", {63'd0, rf_we}, 64'd0);
        acc = in_valid && in_ready;
        e.idx = in_rd_idx; e.val = in_rd_val;
        to_pos;
        if (pop) begin void'(q.pop_front()); exp_retire++; end
        if (acc) begin q.push_back(e); accepted++; end
        cyc++;
      end
      if (accepted < 100) chk("stream.timeout", 64'(accepted), 64'd100);
      idle;
      cyc = 0;
      while (q.size() > 0 && cyc < 10) begin
        @(negedge clk);
        chk("stream.tail.rf_we", {63'd0, rf_we}, 64'd1);
        chk("stream.tail.rf_wdata", rf_wdata, q[0].val);
        to_pos;
        void'(q.pop_front()); exp_retire++;
        cyc++;
      end
      @(negedge clk);
      chk("stream.empty.rf_we", {63'd0, rf_we}, 64'd0);
      chk("stream.retire_cnt", retire_cnt, exp_retire);
      to_pos;
    end

    // Reset while draining after a redirect.
    drive(64'h600, 1, 5'd1, 64'h604, 1, 64'h700, 0);
    to_pos;
    idle;
    to_pos;
    to_pos;
    rst = 0;
    #1;
    chk("rstdrain.redirect_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rstdrain.rf_we", {63'd0, rf_we}, 64'd0);
    chk("rstdrain.rf_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rstdrain.rf_wdata", rf_wdata, 64'd0);
    chk("rstdrain.epc", epc, 64'd0);
    chk("rstdrain.redirect_pc", redirect_pc, 64'd0);
    chk("rstdrain.retire_cnt", retire_cnt, 64'd0);
    chk("rstdrain.in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) to_pos;
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstdrain.no_pulse", {63'd0, redirect_valid}, 64'd0);
      to_pos;
    end
    exp_retire = 0;
    push_commit("rstdrain.first", 64'h800, 1, 5'd9, 64'h5A, 1, 5'd9, 64'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
